hanoi_auto_solver: RTL and testbench
====================================

# hanoi_auto_solver

Auto-play sequencer for the Tower of Hanoi peg datapath. On `start`, it solves the 4-disc puzzle iteratively and issues one legal move per pacing tick to the move-execution logic over a valid/ready handshake. It keeps a shadow copy of the four pegs for display, and reports progress and completion. It sits between the button/switch front end and the peg registers, and replaces manual `btnL`/`btnR` play while active.

## Interface
Parameters:
- `NDISC`, 4: disc count. Fixed at 4; `move_cnt` width and the 15-move limit derive from it.

Ports (one clock; reset is asynchronous and active-low):
- `msclk`  in  1  master clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse; begins a solve from the initial board.
- `abort`  in  1  level; returns to IDLE.
- `mode`  in  1  0: source peg 3, aux peg 1, destination peg 0. 1: source peg 2, aux peg 1, destination peg 0.
- `step_en`  in  1  one-cycle pacing pulse (e.g. from the 1 Hz tick).
- `mv_ready`  in  1  datapath accepts the move.
- `peg_in`  in  16  datapath board `{peg3,peg2,peg1,peg0}`; used only under the macro.
- `mv_valid`  out  1  move offered.
- `mv_src`  out  2  source peg.
- `mv_dst`  out  2  destination peg.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  solve complete.
- `err`  out  1  shadow/datapath mismatch.
- `move_cnt`  out  4  moves completed.
- `peg_state`  out  16  shadow board, same packing as `peg_in`. Bit 0 of each nibble is the smallest disc.

## Operation
- **Board encoding.** Each peg is 4 bits. The top disc is the lowest set bit. A peg is empty when its nibble is 0.
- **IDLE.** `start` moves to LOAD. All other inputs are ignored.
- **LOAD (1 cycle).** Sets `peg_state` to 16'hF000 (mode 0) or 16'h0F00 (mode 1). Clears `move_cnt`, `done` and `err`. Then goes to WAIT_STEP.
- **WAIT_STEP.** On `step_en`, goes to COMPUTE. A `step_en` pulse in any other state is dropped, not queued.
- **COMPUTE (1 cycle).** Registers `mv_src`/`mv_dst`:
  - Even `move_cnt` (0, 2, …): move the smallest disc cyclically src→aux→dst→src.
  - Odd `move_cnt`: take the two pegs not holding disc 0. Move from the peg with the smaller top disc to the other; an empty peg is always the destination.
  - Then goes to ISSUE.
- **ISSUE.** Holds `mv_valid`=1 with `mv_src`/`mv_dst` stable until `mv_valid && mv_ready` is sampled. Then goes to UPDATE.
- **UPDATE (1 cycle).**
  - Moves the top disc in `peg_state` from the source nibble to the destination nibble.
  - Increments `move_cnt`.
  - If the new count is 15, goes to DONE; otherwise goes to WAIT_STEP.
- **DONE.** Holds `done`=1 and `mv_valid`=0. `start` re-enters LOAD.
- **abort.** From any state, goes to IDLE on the next edge. `mv_valid` drops, `done` clears, and `peg_state`/`move_cnt` are retained.
- **Priority:** `abort` > `start`. `start` while `busy` is ignored.
- **Mode sampling.** `mode` is sampled only in LOAD; changes during a solve have no effect.

## Timing
- Reset values: `mv_valid`=0, `mv_src`=0, `mv_dst`=0, `busy`=0, `done`=0, `err`=0, `move_cnt`=0, `peg_state`=16'hF000, state=IDLE.
- `start` to first COMPUTE: LOAD takes 1 cycle, then the first `step_en` seen in WAIT_STEP.
- `step_en` to `mv_valid` high: 2 edges.
- Handshake edge to the next `peg_state`/`move_cnt` update: 1 edge. `mv_valid` falls on the edge after the handshake.
- Minimum spacing between offered moves: 4 cycles (with `step_en` held high).
- `done` rises on the edge after the 15th UPDATE.
- Reset mid-ISSUE: outputs go immediately (asynchronously) to their reset values, and no partial move is recorded.

## Configuration
- `HANOI_SOLVER_CHECK_EN` defined:
  - In COMPUTE, `peg_in` is compared against `peg_state`.
  - On a mismatch, the block goes to an ERR state, `err`=1, `mv_valid` stays 0, and `busy`=0.
  - ERR exits only on `abort` (to IDLE) or `start` (to LOAD).
- `HANOI_SOLVER_CHECK_EN` undefined:
  - `peg_in` is unused.
  - `err` is tied 0.
  - There is no ERR state.

## Test plan
- **Mode 0 full solve.** Reset, `mode`=0, `start`, `mv_ready`=1, `step_en` every 4 cycles.
  - Moves 1–3 are 3→1, 3→0, 1→0.
  - 15 handshakes in total.
  - Ends with `peg_state`=16'h000F, `move_cnt`=15, `done`=1.
- **Mode 1 full solve.** Same stimulus with `mode`=1.
  - First move is 2→1.
  - Ends with `peg_state`=16'h000F and `done`=1.
  - Peg 3 is never used as a source or destination.
- **Backpressure.** Hold `mv_ready`=0 for 5 cycles during move 4.
  - `mv_valid` stays 1, `mv_src`/`mv_dst` stay stable, `move_cnt` stays 3.
  - The move completes one cycle after `mv_ready` rises.
- **Dropped tick and ignored start.** Pulse `step_en` during ISSUE, and pulse `start` while `busy`.
  - No extra move is generated and the solve is not restarted.
  - Exactly 15 moves total.
- **Abort and restart.** Assert `abort` after move 7.
  - Next cycle: IDLE, `mv_valid`=0, `move_cnt`=7 retained.
  - A following `start` reloads 16'hF000 and clears the count.
- **Checker (`HANOI_SOLVER_CHECK_EN`).** Drive `peg_in`=16'hF000 normally, then force it to 16'h0000 before move 2's COMPUTE.
  - `err`=1 and no second `mv_valid`.
  - `abort` clears the block to IDLE.

Source files
------------

// File: rtl/hanoi_auto_solver.sv
// hanoi_auto_solver: iterative Tower of Hanoi auto-player issuing one legal move per step tick.
// Optional shadow/datapath consistency checker enabled by defining HANOI_SOLVER_CHECK_EN.
module hanoi_auto_solver #(
    parameter int unsigned NDISC = 4
) (
    input  logic                 msclk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 mode,
    input  logic                 step_en,
    input  logic                 mv_ready,
    input  logic [4*NDISC-1:0]   peg_in,
    output logic                 mv_valid,
    output logic [1:0]           mv_src,
    output logic [1:0]           mv_dst,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [NDISC-1:0]     move_cnt,
    output logic [4*NDISC-1:0]   peg_state
);

    localparam int unsigned PEG_W     = NDISC;
    localparam int unsigned BOARD_W   = 4 * NDISC;
    localparam int unsigned LAST_MOVE = (1 << NDISC) - 1;
    localparam logic [BOARD_W-1:0] FULL_PEG = BOARD_W'({PEG_W{1'b1}});
    localparam logic [BOARD_W-1:0] INIT_M0  = FULL_PEG << (3 * PEG_W);
    localparam logic [BOARD_W-1:0] INIT_M1  = FULL_PEG << (2 * PEG_W);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT, S_COMPUTE, S_ISSUE, S_UPDATE,
`ifdef HANOI_SOLVER_CHECK_EN
        S_DONE, S_ERR
`else
        S_DONE
`endif
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_mode, w_mode_nxt;
    logic                 r_valid, w_valid_nxt;
    logic [1:0]           r_src, w_src_nxt;
    logic [1:0]           r_dst, w_dst_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic [NDISC-1:0]     r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [BOARD_W-1:0]   r_peg, w_peg_nxt, w_peg_upd;

    logic [1:0]           w_src_peg, w_pa, w_pb, w_small_src, w_small_dst;
    logic [1:0]           w_odd_src, w_odd_dst, w_mv_src, w_mv_dst;
    logic [PEG_W-1:0]     w_s_nib, w_a_nib, w_ta, w_tb, w_low_src;

    function automatic logic [PEG_W-1:0] nib(input logic [BOARD_W-1:0] b, input logic [1:0] p);
        return b[p*PEG_W +: PEG_W];
    endfunction

    // Isolates the lowest set bit, i.e. the top disc of a peg (0 when empty).
    function automatic logic [PEG_W-1:0] low_bit(input logic [PEG_W-1:0] x);
        return x & (~x + PEG_W'(1));
    endfunction

    assign w_src_peg = r_mode ? 2'd2 : 2'd3;

    // Move selection: smallest disc cycles src->aux->dst; otherwise the only other legal move.
    always_comb begin
        w_s_nib = nib(r_peg, w_src_peg);
        w_a_nib = nib(r_peg, 2'd1);
        if (w_s_nib[0]) begin
            w_small_src = w_src_peg; w_small_dst = 2'd1;
            w_pa = 2'd1;             w_pb = 2'd0;
        end else if (w_a_nib[0]) begin
            w_small_src = 2'd1;      w_small_dst = 2'd0;
            w_pa = w_src_peg;        w_pb = 2'd0;
        end else begin
            w_small_src = 2'd0;      w_small_dst = w_src_peg;
            w_pa = w_src_peg;        w_pb = 2'd1;
        end
        w_ta = low_bit(nib(r_peg, w_pa));
        w_tb = low_bit(nib(r_peg, w_pb));
        if (w_ta == '0) begin
            w_odd_src = w_pb; w_odd_dst = w_pa;
        end else if ((w_tb == '0) || (w_ta < w_tb)) begin
            w_odd_src = w_pa; w_odd_dst = w_pb;
        end else begin
            w_odd_src = w_pb; w_odd_dst = w_pa;
        end
        w_mv_src = r_cnt[0] ? w_odd_src : w_small_src;
        w_mv_dst = r_cnt[0] ? w_odd_dst : w_small_dst;
    end

    assign w_low_src = low_bit(nib(r_peg, r_src));
    assign w_peg_upd = (r_peg & ~(BOARD_W'(w_low_src) << (r_src * PEG_W)))
                     | (BOARD_W'(w_low_src) << (r_dst * PEG_W));
    assign w_cnt_inc = r_cnt + NDISC'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        w_cnt_nxt   = r_cnt;
        w_peg_nxt   = r_peg;
        case (r_state)
            S_IDLE:    if (start) w_state_nxt = S_LOAD;
            S_LOAD: begin
                w_mode_nxt  = mode;
                w_peg_nxt   = mode ? INIT_M1 : INIT_M0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT:    if (step_en) w_state_nxt = S_COMPUTE;
            S_COMPUTE: begin
                w_src_nxt   = w_mv_src;
                w_dst_nxt   = w_mv_dst;
                w_state_nxt = S_ISSUE;
`ifdef HANOI_SOLVER_CHECK_EN
                if (peg_in != r_peg) w_state_nxt = S_ERR;
`endif
            end
            S_ISSUE:   if (mv_ready) w_state_nxt = S_UPDATE;
            S_UPDATE: begin
                w_peg_nxt   = w_peg_upd;
                w_cnt_nxt   = w_cnt_inc;
                w_state_nxt = (w_cnt_inc == NDISC'(LAST_MOVE)) ? S_DONE : S_WAIT;
            end
            S_DONE:    if (start) w_state_nxt = S_LOAD;
`ifdef HANOI_SOLVER_CHECK_EN
            S_ERR:     if (start) w_state_nxt = S_LOAD;
`endif
            default:   w_state_nxt = S_IDLE;
        endcase
        // Abort wins over everything but keeps the board and count for display.
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_mode_nxt  = r_mode;
            w_cnt_nxt   = r_cnt;
            w_peg_nxt   = r_peg;
        end
        w_valid_nxt = (w_state_nxt == S_ISSUE);
        w_done_nxt  = (w_state_nxt == S_DONE);
        w_busy_nxt  = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
`ifdef HANOI_SOLVER_CHECK_EN
        w_busy_nxt  = w_busy_nxt && (w_state_nxt != S_ERR);
`endif
    end

    always_ff @(posedge msclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_valid <= 1'b0;
            r_src   <= 2'd0;
            r_dst   <= 2'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_peg   <= INIT_M0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_valid <= w_valid_nxt;
            r_src   <= w_src_nxt;
            r_dst   <= w_dst_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_cnt   <= w_cnt_nxt;
            r_peg   <= w_peg_nxt;
        end
    end

`ifdef HANOI_SOLVER_CHECK_EN
    logic r_err;
    always_ff @(posedge msclk or negedge rst_n) begin
        if (!rst_n) r_err <= 1'b0;
        else        r_err <= (w_state_nxt == S_ERR);
    end
    assign err = r_err;
`else
    logic w_unused_peg_in;
    assign w_unused_peg_in = ^peg_in;
    assign err = 1'b0;
`endif

    assign mv_valid  = r_valid;
    assign mv_src    = r_src;
    assign mv_dst    = r_dst;
    assign busy      = r_busy;
    assign done      = r_done;
    assign move_cnt  = r_cnt;
    assign peg_state = r_peg;

endmodule

// File: tb/tb_hanoi_auto_solver.sv
// tb_hanoi_auto_solver: randomized self-checking bench; expected moves come from the closed-form
// binary Hanoi solution, expected boards from a disc-position array.
module tb_hanoi_auto_solver;

    logic        msclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        mode = 1'b0;
    logic        step_en = 1'b0;
    logic        mv_ready = 1'b0;
    logic [15:0] peg_in = 16'hF000;
    logic        mv_valid, busy, done, err;
    logic [1:0]  mv_src, mv_dst;
    logic [3:0]  move_cnt;
    logic [15:0] peg_state;

    int n_pass = 0;
    int n_total = 0;

    logic [1:0]  exp_src[15];
    logic [1:0]  exp_dst[15];
    logic [15:0] exp_board[16];

    hanoi_auto_solver #(.NDISC(4)) dut (
        .msclk(msclk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .step_en(step_en), .mv_ready(mv_ready), .peg_in(peg_in),
        .mv_valid(mv_valid), .mv_src(mv_src), .mv_dst(mv_dst), .busy(busy),
        .done(done), .err(err), .move_cnt(move_cnt), .peg_state(peg_state)
    );

    always #5 msclk = ~msclk;

    task automatic tick();
        @(posedge msclk);
        #1;
    endtask

    // Logical pegs of the binary solution: 0 = source, 1 = destination, 2 = auxiliary (even disc count).
    function automatic int phys(input int l, input int sp);
        return (l == 0) ? sp : ((l == 1) ? 0 : 1);
    endfunction

    task automatic build_model(input logic md);
        int pos[4];
        int sp, ls, ld, dsc;
        logic [15:0] b;
        sp = md ? 2 : 3;
        for (int d = 0; d < 4; d++) pos[d] = sp;
        b = '0;
        for (int d = 0; d < 4; d++) b[pos[d]*4 + d] = 1'b1;
        exp_board[0] = b;
        for (int m = 1; m <= 15; m++) begin
            ls = (m & (m - 1)) % 3;
            ld = ((m | (m - 1)) + 1) % 3;
            exp_src[m-1] = 2'(phys(ls, sp));
            exp_dst[m-1] = 2'(phys(ld, sp));
            dsc = 0;
            while (((m >> dsc) & 1) == 0) dsc++;
            pos[dsc] = phys(ld, sp);
            b = '0;
            for (int d = 0; d < 4; d++) b[pos[d]*4 + d] = 1'b1;
            exp_board[m] = b;
        end
    endtask

    // Stimulus only: one full move with mv_ready high, starting from WAIT_STEP.
    task automatic do_move(input int j);
        step_en = 1'b1; tick(); step_en = 1'b0;
        tick(); tick(); tick();
        peg_in = exp_board[j+1];
    endtask

    task automatic begin_solve(input logic md);
        build_model(md);
        mode = md; peg_in = exp_board[0];
        start = 1'b1; tick(); start = 1'b0;
        tick();
        mode = 1'($urandom);
    endtask

    task automatic run_solve(input string tag, input logic md, input int step_kind,
                             input int ready_pct, input bit noise);
        int k, pk, cyc, extra_valid;
        bit pend, hs, used3;
        logic [1:0] got_src[15];
        logic [1:0] got_dst[15];
        begin_solve(md);
        k = 0; pk = 0; cyc = 0; pend = 0; used3 = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            step_en  = (step_kind == 0) ? (cyc % 4 == 0) :
                       (step_kind == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
            mv_ready = ($urandom_range(1, 100) <= ready_pct);
            start    = noise && busy && ($urandom_range(0, 7) == 0);
            hs = mv_valid && mv_ready;
            if (hs) begin
                if (k < 15) begin got_src[k] = mv_src; got_dst[k] = mv_dst; end
                n_total++;
                if (k >= 15 || mv_src !== exp_src[k % 15] || mv_dst !== exp_dst[k % 15])
                    $display("FAIL %s move%0d: got %0d->%0d want %0d->%0d", tag, k + 1, mv_src, mv_dst, exp_src[k % 15], exp_dst[k % 15]);
                else n_pass++;
                if (mv_src == 2'd3 || mv_dst == 2'd3) used3 = 1'b1;
                pk = k; k++;
            end
            tick(); cyc++;
            start = 1'b0;
            if (pend) begin
                n_total++;
                if (move_cnt !== 4'(pk + 1)) $display("FAIL %s cnt_after%0d: got %0d want %0d", tag, pk + 1, move_cnt, pk + 1);
                else n_pass++;
                n_total++;
                if (peg_state !== exp_board[(pk + 1) % 16]) $display("FAIL %s board_after%0d: got %h want %h", tag, pk + 1, peg_state, exp_board[(pk + 1) % 16]);
                else n_pass++;
                peg_in = exp_board[(pk + 1) % 16];
                pend = 0;
            end
            if (hs) begin
                n_total++;
                if (mv_valid !== 1'b0) $display("FAIL %s valid_fall%0d: got %b want 0", tag, pk + 1, mv_valid);
                else n_pass++;
                pend = 1;
            end
        end
        step_en = 1'b0; start = 1'b0;
        n_total++; if (done !== 1'b1) $display("FAIL %s done: got %b want 1", tag, done); else n_pass++;
        n_total++; if (k !== 15) $display("FAIL %s handshakes: got %0d want 15", tag, k); else n_pass++;
        n_total++; if (move_cnt !== 4'd15) $display("FAIL %s final_cnt: got %0d want 15", tag, move_cnt); else n_pass++;
        n_total++; if (peg_state !== 16'h000F) $display("FAIL %s final_board: got %h want 000f", tag, peg_state); else n_pass++;
        n_total++; if (busy !== 1'b0 || err !== 1'b0) $display("FAIL %s final_busy_err: got %b%b want 00", tag, busy, err); else n_pass++;
        extra_valid = 0;
        step_en = 1'b1; mv_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin tick(); if (mv_valid) extra_valid++; end
        step_en = 1'b0;
        n_total++; if (extra_valid != 0 || done !== 1'b1) $display("FAIL %s after_done: got %0d offers done=%b want 0 offers done=1", tag, extra_valid, done); else n_pass++;
        if (md == 1'b0 && step_kind == 0) begin
            n_total++;
            if (got_src[0] !== 2'd3 || got_dst[0] !== 2'd1 || got_src[1] !== 2'd3 || got_dst[1] !== 2'd0 || got_src[2] !== 2'd1 || got_dst[2] !== 2'd0)
                $display("FAIL %s first_moves: got %0d->%0d %0d->%0d %0d->%0d want 3->1 3->0 1->0", tag, got_src[0], got_dst[0], got_src[1], got_dst[1], got_src[2], got_dst[2]);
            else n_pass++;
        end
        if (md == 1'b1) begin
            n_total++; if (got_src[0] !== 2'd2 || got_dst[0] !== 2'd1) $display("FAIL %s first_move_m1: got %0d->%0d want 2->1", tag, got_src[0], got_dst[0]); else n_pass++;
            n_total++; if (used3 !== 1'b0) $display("FAIL %s peg3_used: got %b want 0", tag, used3); else n_pass++;
        end
    endtask

    task automatic test_reset();
        #12;
        n_total++; if (mv_valid !== 1'b0 || mv_src !== 2'd0 || mv_dst !== 2'd0) $display("FAIL reset_move: got v=%b %0d->%0d want v=0 0->0", mv_valid, mv_src, mv_dst); else n_pass++;
        n_total++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) $display("FAIL reset_flags: got %b%b%b want 000", busy, done, err); else n_pass++;
        n_total++; if (move_cnt !== 4'd0) $display("FAIL reset_cnt: got %0d want 0", move_cnt); else n_pass++;
        n_total++; if (peg_state !== 16'hF000) $display("FAIL reset_board: got %h want f000", peg_state); else n_pass++;
        #6 rst_n = 1'b1;
        step_en = 1'b1; tick(); tick(); step_en = 1'b0;
        n_total++; if (busy !== 1'b0 || mv_valid !== 1'b0) $display("FAIL idle_ignores_step: got busy=%b v=%b want 0 0", busy, mv_valid); else n_pass++;
    endtask

    task automatic test_mode0_full(); run_solve("mode0", 1'b0, 0, 100, 1'b0); endtask
    task automatic test_mode1_full(); run_solve("mode1", 1'b1, 0, 100, 1'b0); endtask

    task automatic test_backpressure();
        mv_ready = 1'b1;
        begin_solve(1'b0);
        for (int j = 0; j < 3; j++) do_move(j);
        step_en = 1'b1; tick(); step_en = 1'b0;
        mv_ready = 1'b0; tick();
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (mv_valid !== 1'b1 || mv_src !== exp_src[3] || mv_dst !== exp_dst[3] || move_cnt !== 4'd3)
                $display("FAIL bp_hold%0d: got v=%b %0d->%0d cnt=%0d want v=1 %0d->%0d cnt=3", i, mv_valid, mv_src, mv_dst, move_cnt, exp_src[3], exp_dst[3]);
            else n_pass++;
            tick();
        end
        mv_ready = 1'b1; tick();
        n_total++; if (mv_valid !== 1'b0 || move_cnt !== 4'd3) $display("FAIL bp_handshake: got v=%b cnt=%0d want v=0 cnt=3", mv_valid, move_cnt); else n_pass++;
        tick();
        n_total++; if (move_cnt !== 4'd4 || peg_state !== exp_board[4]) $display("FAIL bp_update: got cnt=%0d %h want cnt=4 %h", move_cnt, peg_state, exp_board[4]); else n_pass++;
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic test_abort_restart();
        mv_ready = 1'b1;
        begin_solve(1'b0);
        for (int j = 0; j < 7; j++) do_move(j);
        n_total++; if (move_cnt !== 4'd7) $display("FAIL abort_pre_cnt: got %0d want 7", move_cnt); else n_pass++;
        abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
        n_total++; if (busy !== 1'b0 || mv_valid !== 1'b0 || done !== 1'b0) $display("FAIL abort_idle: got busy=%b v=%b done=%b want 000", busy, mv_valid, done); else n_pass++;
        n_total++; if (move_cnt !== 4'd7 || peg_state !== exp_board[7]) $display("FAIL abort_keep: got cnt=%0d %h want 7 %h", move_cnt, peg_state, exp_board[7]); else n_pass++;
        step_en = 1'b1; tick(); tick(); step_en = 1'b0;
        n_total++; if (busy !== 1'b0 || mv_valid !== 1'b0) $display("FAIL abort_stay_idle: got busy=%b v=%b want 0 0", busy, mv_valid); else n_pass++;
        begin_solve(1'b0);
        n_total++; if (peg_state !== 16'hF000 || move_cnt !== 4'd0 || busy !== 1'b1) $display("FAIL restart_load: got %h cnt=%0d busy=%b want f000 0 1", peg_state, move_cnt, busy); else n_pass++;
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic test_step_held();
        int offers;
        logic md;
        md = 1'($urandom);
        build_model(md);
        mode = md; peg_in = exp_board[0]; mv_ready = 1'b1; step_en = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        offers = 0;
        for (int e = 2; e <= 61; e++) begin
            tick();
            if (mv_valid) begin offers++; peg_in = exp_board[offers]; end
        end
        n_total++; if (done !== 1'b0) $display("FAIL held_done_early: got %b want 0", done); else n_pass++;
        tick();
        n_total++; if (done !== 1'b1 || offers != 15) $display("FAIL held_timing: got done=%b offers=%0d want 1 15", done, offers); else n_pass++;
        step_en = 1'b0;
    endtask

    task automatic test_reset_mid_issue();
        mv_ready = 1'b0;
        begin_solve(1'b0);
        step_en = 1'b1; tick(); step_en = 1'b0; tick();
        n_total++; if (mv_valid !== 1'b1) $display("FAIL rst_mid_pre: got v=%b want 1", mv_valid); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (mv_valid !== 1'b0 || busy !== 1'b0 || mv_src !== 2'd0 || mv_dst !== 2'd0) $display("FAIL rst_mid_async: got v=%b busy=%b %0d->%0d want 0 0 0->0", mv_valid, busy, mv_src, mv_dst); else n_pass++;
        n_total++; if (move_cnt !== 4'd0 || peg_state !== 16'hF000) $display("FAIL rst_mid_state: got cnt=%0d %h want 0 f000", move_cnt, peg_state); else n_pass++;
        @(negedge msclk); rst_n = 1'b1;
        mv_ready = 1'b1; tick(); tick();
        n_total++; if (move_cnt !== 4'd0 || busy !== 1'b0) $display("FAIL rst_mid_after: got cnt=%0d busy=%b want 0 0", move_cnt, busy); else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++)
            run_solve($sformatf("rand%0d", it), 1'($urandom), $urandom_range(0, 2), $urandom_range(30, 100), 1'b1);
    endtask

`ifdef HANOI_SOLVER_CHECK_EN
    task automatic test_checker();
        int offers;
        mv_ready = 1'b1;
        begin_solve(1'b0);
        do_move(0);
        peg_in = 16'h0000;
        step_en = 1'b1; tick(); step_en = 1'b0;
        offers = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (mv_valid) offers++; end
        n_total++; if (err !== 1'b1 || busy !== 1'b0 || offers != 0) $display("FAIL chk_err: got err=%b busy=%b offers=%0d want 1 0 0", err, busy, offers); else n_pass++;
        abort = 1'b1; tick(); abort = 1'b0;
        n_total++; if (err !== 1'b0 || busy !== 1'b0 || mv_valid !== 1'b0) $display("FAIL chk_abort: got err=%b busy=%b v=%b want 000", err, busy, mv_valid); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_mode0_full();
        test_mode1_full();
        test_backpressure();
        test_abort_restart();
        test_step_held();
        test_reset_mid_issue();
        test_random();
`ifdef HANOI_SOLVER_CHECK_EN
        test_checker();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
